// File: rtl/hs_word_packer.sv
// Valid/ready width up-converter: packs RATIO upstream words into one beat,
// with LAST_UP closing a partial beat early. First word lands at bits [0:WIDTH-1].
module hs_word_packer #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO) + 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     VALID_UP,
    output logic                     READY_UP,
    input  logic [0:WIDTH-1]         DATA_UP,
    input  logic                     LAST_UP,
    output logic                     VALID_DOWN,
    input  logic                     READY_DOWN,
    output logic [0:WIDTH*RATIO-1]   DATA_DOWN,
    output logic [CW-1:0]            COUNT_DOWN,
    output logic                     LAST_DOWN
);

    localparam int SW = $clog2(RATIO);

    logic [SW-1:0]          cnt;
    logic [0:WIDTH-1]       slot [RATIO-1];
    logic                   out_valid;
    logic                   accept;
    logic                   complete;
    logic [0:WIDTH*RATIO-1] beat;

    // Ready depends only on the output register and READY_DOWN, never on VALID_UP.
    assign READY_UP   = ~RESET && (~out_valid || READY_DOWN);
    assign accept     = VALID_UP && READY_UP;
    assign complete   = accept && ((cnt == SW'(RATIO - 1)) || LAST_UP);
    assign VALID_DOWN = out_valid;

    always_comb begin
        beat = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (SW'(i) < cnt) begin
                beat[i*WIDTH +: WIDTH] = slot[i];
            end else if (SW'(i) == cnt) begin
                beat[i*WIDTH +: WIDTH] = DATA_UP;
            end
        end
        if (cnt == SW'(RATIO - 1)) begin
            beat[(RATIO-1)*WIDTH +: WIDTH] = DATA_UP;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid  <= 1'b0;
            DATA_DOWN  <= '0;
            COUNT_DOWN <= '0;
            LAST_DOWN  <= 1'b0;
            cnt        <= '0;
            for (int i = 0; i < RATIO - 1; i++) begin
                slot[i] <= '0;
            end
        end else if (complete) begin
            // A completing word overwrites any beat draining in the same cycle.
            out_valid  <= 1'b1;
            DATA_DOWN  <= beat;
            COUNT_DOWN <= CW'(cnt) + CW'(1);
            LAST_DOWN  <= LAST_UP;
            cnt        <= '0;
            for (int i = 0; i < RATIO - 1; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (out_valid && READY_DOWN) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                cnt <= cnt + SW'(1);
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (cnt == SW'(i)) begin
                        slot[i] <= DATA_UP;
                    end
                end
            end
        end
    end

endmodule
